button_debounce: RTL



---
 rtl/button_debounce_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types for the push-button debouncer.
// The debounce FSM state encoding lives here so other pin front-ends can reuse it.
package button_debounce_pkg;

  // Debounce FSM states: stable released, press candidate, stable pressed, release candidate
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // True while the button is in the accepted-pressed half of the FSM
  function automatic logic state_is_held(input btn_state_t st);
    return (st == PRESSED) || (st == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Resets to 0 with its own asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the asynchronous input, then re-register to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: clean level plus single-cycle press/release pulses.
// Optional long-press pulse is compiled in with `define BUTTON_DEBOUNCE_LONG_EN;
// without it btn_long is tied 0 and no hold counter exists.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic             btn_norm;
  logic             sync_s;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             press_d;
  logic             release_d;
`ifdef BUTTON_DEBOUNCE_LONG_EN
  logic             hold_clr;
`endif

  // Normalise polarity so 1 always means pressed
  assign btn_norm = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  // Bring the pin into the clock domain
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_norm),
    .q   (sync_s)
  );

  // Next-state, stability counter and pulse decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_EN
    hold_clr  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sync_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = PRESSED;
          press_d  = 1'b1;
          level_d  = 1'b1;
`ifdef BUTTON_DEBOUNCE_LONG_EN
          hold_clr = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              fired_q;
  logic              fired_d;
  logic              long_d;

  // Hold counter saturates at its last value; fired flag blocks repeat pulses
  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (hold_clr) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (state_is_held(state_q)) begin
      if (hold_q == HOLD_LAST) begin
        if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  // Hold counter and long-press pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= '0;
      fired_q  <= 1'b0;
      btn_long <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      fired_q  <= fired_d;
      btn_long <= long_d;
    end
  end
`else
  // Long-press feature absent
  assign btn_long = 1'b0;
`endif

endmodule
